// File: rtl/par_to_ser_tx.sv
// Parallel-to-serial transmitter: gapless LSB-first stream, one word buffered
// behind the frame in flight, IDLE_WORD frames flagged by a one-cycle underrun.
module par_to_ser_tx #(
   parameter int                 DATA_W    = 8,
   parameter logic [DATA_W-1:0]  IDLE_WORD = '0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [DATA_W-1:0] par_in,
   input  logic              par_valid,
   output logic              par_ready,
   output logic              ser_out,
   output logic              frame_start,
   output logic              underrun,
   output logic [15:0]       tx_count
);

   localparam int CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;
   localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_W - 1);

   logic [CNT_W-1:0]  r_bit_cnt;
   logic [DATA_W-1:0] r_shreg;
   logic [DATA_W-1:0] r_hold;
   logic              r_hold_valid;
   logic              r_underrun;
   logic [15:0]       r_tx_count;

   logic              w_load;
   logic              w_accept;

   assign w_load      = (r_bit_cnt == LAST_BIT);
   // Ready depends only on the holding flag, so no path from par_valid.
   assign w_accept    = par_valid && !r_hold_valid;

   assign par_ready   = !r_hold_valid;
   assign ser_out     = r_shreg[0];
   assign frame_start = (r_bit_cnt == '0);
   assign underrun    = r_underrun;
   assign tx_count    = r_tx_count;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_bit_cnt    <= '0;
         r_shreg      <= IDLE_WORD;
         r_hold       <= '0;
         r_hold_valid <= 1'b0;
         r_underrun   <= 1'b0;
         r_tx_count   <= '0;
      end else begin
         r_underrun <= 1'b0;
         r_bit_cnt  <= w_load ? '0 : r_bit_cnt + CNT_W'(1);
         if (w_accept)
            r_tx_count <= r_tx_count + 16'd1;

         if (w_load) begin
            // Held word has priority; otherwise a same-edge accept bypasses the hold.
            if (r_hold_valid) begin
               r_shreg      <= r_hold;
               r_hold_valid <= 1'b0;
            end else if (w_accept) begin
               r_shreg      <= par_in;
            end else begin
               r_shreg      <= IDLE_WORD;
               r_underrun   <= 1'b1;
            end
         end else begin
            r_shreg <= {1'b0, r_shreg[DATA_W-1:1]};
            if (w_accept) begin
               r_hold       <= par_in;
               r_hold_valid <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_par_to_ser_tx.sv
// Directed bench for par_to_ser_tx (DATA_W=8): idle stream, handshake,
// bypass, back-pressure, mid-frame reset and a randomized loopback.
module tb_par_to_ser_tx;

   logic       clk = 1'b0;
   logic       reset;
   logic [7:0] par_in;
   logic       par_valid;
   logic       par_ready;
   logic       ser_out;
   logic       frame_start;
   logic       underrun;
   logic [15:0] tx_count;

   par_to_ser_tx #(.DATA_W(8), .IDLE_WORD(8'h00)) dut (
      .clk(clk), .reset(reset), .par_in(par_in), .par_valid(par_valid),
      .par_ready(par_ready), .ser_out(ser_out), .frame_start(frame_start),
      .underrun(underrun), .tx_count(tx_count)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int failures = 0;
   int cyc;
   bit gappy = 0;
   bit deser_on = 0;
   logic ser_log [0:255];
   logic fs_log  [0:255];
   logic ur_log  [0:255];
   logic rdy_log [0:255];
   logic [7:0] offer_q [$];
   logic [7:0] exp_q [$];
   logic [7:0] got_q [$];
   logic [7:0] ds_word;
   int         ds_k = 8;
   logic       ds_ur;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $display("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
         $error("%s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Record the current cycle and run the reference deserializer on it.
   task automatic sample();
      if (cyc < 256) begin
         ser_log[cyc] = ser_out;
         fs_log[cyc]  = frame_start;
         ur_log[cyc]  = underrun;
         rdy_log[cyc] = par_ready;
      end
      if (deser_on) begin
         if (frame_start) begin
            ds_k  = 0;
            ds_ur = underrun;
         end
         if (ds_k < 8) begin
            ds_word[ds_k] = ser_out;
            if (ds_k == 7 && !ds_ur) got_q.push_back(ds_word);
            ds_k++;
         end
      end
   endtask

   task automatic step();
      logic acc;
      if (offer_q.size() > 0 && (!gappy || $urandom_range(3) != 0)) begin
         par_valid = 1'b1;
         par_in    = offer_q[0];
      end else begin
         par_valid = 1'b0;
         par_in    = 8'h00;
      end
      acc = par_valid && par_ready;
      @(posedge clk);
      @(negedge clk);
      if (acc) void'(offer_q.pop_front());
      cyc++;
      sample();
   endtask

   task automatic run_to(input int c);
      while (cyc < c) step();
   endtask

   task automatic release_reset();
      @(negedge clk);
      reset = 1'b0;
      cyc   = 0;
      sample();
   endtask

   initial begin
      logic [23:0] s32;
      logic [7:0]  s81;
      logic [15:0] s34;
      int budget;
      reset = 1'b1; par_valid = 1'b0; par_in = 8'h00;
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_ser", ser_out, 0);
      chk("rst_fs", frame_start, 1);
      chk("rst_rdy", par_ready, 1);
      chk("rst_ur", underrun, 0);
      par_valid = 1'b1; par_in = 8'h55;
      repeat (2) @(negedge clk);
      chk("rst_no_accept", tx_count, 0);
      chk("rst_rdy_hold", par_ready, 1);
      par_valid = 1'b0;

      // Idle stream after release
      release_reset();
      run_to(24);
      for (int c = 0; c < 24; c++) begin
         chk($sformatf("idle_fs[%0d]", c), fs_log[c], (c % 8) == 0);
         chk($sformatf("idle_ser[%0d]", c), ser_log[c], 0);
         chk($sformatf("idle_ur[%0d]", c), ur_log[c], (c == 8 || c == 16));
      end

      // Three words, par_valid held high
      offer_q.push_back(8'hA5); offer_q.push_back(8'h3C); offer_q.push_back(8'hFF);
      run_to(56);
      s32 = 24'hFF3CA5;
      for (int c = 32; c < 56; c++) chk($sformatf("str_ser[%0d]", c), ser_log[c], s32[c-32]);
      for (int c = 25; c < 56; c++) chk($sformatf("str_ur[%0d]", c), ur_log[c], 0);
      for (int c = 24; c < 56; c++) chk($sformatf("str_fs[%0d]", c), fs_log[c], (c % 8) == 0);
      chk("str_ur_after", ur_log[56], 1);
      chk("str_txcnt", tx_count, 3);

      // Offer exactly at the load edge: bypass
      run_to(63);
      offer_q.push_back(8'h81);
      run_to(73);
      s81 = 8'h81;
      for (int c = 64; c < 72; c++) chk($sformatf("byp_ser[%0d]", c), ser_log[c], s81[c-64]);
      chk("byp_ur", ur_log[64], 0);
      chk("byp_rdy", rdy_log[64], 1);
      chk("byp_ur_next", ur_log[72], 1);
      chk("byp_txcnt", tx_count, 4);

      // Back-to-back mid-frame, then queue a frame for the reset test
      run_to(74);
      offer_q.push_back(8'h5A); offer_q.push_back(8'hC3);
      run_to(89);
      offer_q.push_back(8'hF0); offer_q.push_back(8'h0F);
      run_to(100);
      for (int c = 75; c < 80; c++) chk($sformatf("bb_rdy[%0d]", c), rdy_log[c], 0);
      chk("bb_rdy80", rdy_log[80], 1);
      s34 = 16'hC35A;
      for (int c = 80; c < 96; c++) chk($sformatf("bb_ser[%0d]", c), ser_log[c], s34[c-80]);
      chk("bb_ur80", ur_log[80], 0);
      chk("bb_ur88", ur_log[88], 0);
      chk("bb_ur96", ur_log[96], 0);
      chk("bb_rdy97", rdy_log[97], 0);
      chk("pre_rst_ser", ser_log[100], 1);
      chk("pre_rst_txcnt", tx_count, 8);

      // Reset at bit_cnt=4 with 8'h0F held
      offer_q.delete();
      par_valid = 1'b0;
      reset = 1'b1;
      #1;
      chk("mrst_ser", ser_out, 0);
      chk("mrst_fs", frame_start, 1);
      chk("mrst_rdy", par_ready, 1);
      chk("mrst_ur", underrun, 0);
      chk("mrst_txcnt", tx_count, 0);
      @(posedge clk);
      release_reset();
      run_to(24);
      for (int c = 0; c < 24; c++) begin
         chk($sformatf("post_ser[%0d]", c), ser_log[c], 0);
         chk($sformatf("post_ur[%0d]", c), ur_log[c], (c == 8 || c == 16));
      end
      chk("post_txcnt", tx_count, 0);

      // Loopback through the reference deserializer with random gaps
      deser_on = 1; gappy = 1;
      for (int i = 0; i < 256; i++) begin
         logic [7:0] w;
         w = 8'($urandom);
         offer_q.push_back(w);
         exp_q.push_back(w);
      end
      budget = 0;
      while (got_q.size() < 256 && budget < 8000) begin
         step();
         budget++;
      end
      chk("lb_count", got_q.size(), 256);
      for (int i = 0; i < 256 && i < got_q.size(); i++)
         chk($sformatf("lb_word[%0d]", i), got_q[i], exp_q[i]);
      chk("lb_txcnt", tx_count, 256);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/par_to_ser_tx.md
PAR_TO_SER_TX -- requirements
Module: par_to_ser_tx

Interface
REQ-001 Parameter: DATA_W, default 8, the frame width in bits (legal 2..32).
REQ-002 Parameter: IDLE_WORD, default all-zeros, DATA_W wide, the word transmitted when no data is available.
REQ-003 Port: clk  input  1  rising-edge clock, bit rate.
REQ-004 Port: reset  input  1  asynchronous, active-high reset.
REQ-005 Port: par_in  input  DATA_W  parallel word to transmit.
REQ-006 Port: par_valid  input  1  par_in holds a valid word.
REQ-007 Port: par_ready  output  1  block accepts par_in this cycle.
REQ-008 Port: ser_out  output  1  serial bitstream, LSB first, continuous.
REQ-009 Port: frame_start  output  1  high during the cycle ser_out carries bit 0 of a frame.
REQ-010 Port: underrun  output  1  one-cycle pulse marking a frame filled with IDLE_WORD.
REQ-011 Port: tx_count  output  16  count of accepted words, wrapping.

Function
REQ-012 Internal state: bit counter bit_cnt (0..DATA_W-1), shift register shreg (DATA_W), one-entry holding register hold_reg with flag hold_valid.
REQ-013 bit_cnt increments every clock, wrapping from DATA_W-1 to 0, and is never stalled; the stream is gapless.
REQ-014 A load edge is any rising clk edge at which bit_cnt == DATA_W-1.
REQ-015 ser_out shall equal shreg[0]; on every non-load edge shreg shifts right by one, MSB filled with 0.
REQ-016 frame_start shall be high exactly when bit_cnt == 0.
REQ-017 par_ready shall equal !hold_valid (no combinational path from par_valid).
REQ-018 Accept = par_valid && par_ready at a rising edge; par_in is captured and tx_count increments by 1 mod 2^16.
REQ-019 At a non-load edge, an accept writes hold_reg and sets hold_valid.
REQ-020 At a load edge with hold_valid = 1: shreg <= hold_reg, hold_valid <= 0; a simultaneous accept is impossible (par_ready = 0).
REQ-021 At a load edge with hold_valid = 0 and an accept: par_in bypasses directly into shreg, hold_valid remains 0, no underrun.
REQ-022 At a load edge with hold_valid = 0 and no accept: shreg <= IDLE_WORD and underrun is asserted for the following cycle only (coincident with that frame's frame_start).
REQ-023 Latency: a word loaded at load edge E drives bit k on ser_out during cycle E+1+k, for k = 0..DATA_W-1.
REQ-024 Throughput: one word per DATA_W cycles sustained; at most one word buffered beyond the frame in flight.
REQ-025 Words are transmitted in acceptance order; no word is dropped or duplicated.
REQ-026 Bit ordering matches the downstream deserializer: bit 0 is sent on the frame_start cycle, bit i on the i-th cycle after.

Reset
REQ-027 reset asynchronously forces bit_cnt = 0, shreg = IDLE_WORD, hold_valid = 0, hold_reg = 0, tx_count = 0, underrun = 0.
REQ-028 During reset: ser_out = IDLE_WORD[0], frame_start = 1, par_ready = 1, but no accept takes effect.
REQ-029 The first frame after reset release is IDLE_WORD and shall not raise underrun.
REQ-030 Reset asserted mid-frame discards the frame in flight and the held word; no partial frame resumes.

Verification
REQ-031 Reset release, par_valid = 0 for 24 cycles (DATA_W = 8) -> frame_start at cycles 0, 8, 16; ser_out all 0; underrun pulses at cycles 8 and 16 only.
REQ-032 par_valid held high with 8'hA5, 8'h3C, 8'hFF -> gapless stream of LSB-first bits 1,0,1,0,0,1,0,1 / 0,0,1,1,1,1,0,0 / all 1; tx_count = 3; no underrun between them.
REQ-033 Single word 8'h81 offered exactly at a load edge with the hold register empty -> bypass; the next frame is 1,0,0,0,0,0,0,1; underrun stays low.
REQ-034 Two words offered back-to-back mid-frame -> first accepted, par_ready low until the next load edge, second accepted after it; both frames follow in order.
REQ-035 Reset pulsed at bit_cnt = 4 with one word held -> outputs immediately at reset values; the held word is never transmitted; tx_count = 0.
REQ-036 Loopback into the 8-bit deserializer, 256 random words -> every word is recovered in order, aligned to frame_start.
